// File: rtl/bf16_pwl_cfg_loader.sv
// Loads the BF16 piecewise-linear coefficient register file from table memory.
// Each table read is replayed onto the cfg write port one cycle after it is accepted.
module bf16_pwl_cfg_loader #(
  parameter int N_SEG      = 13,
  parameter int ADDR_W     = 10,
  parameter int TABLE_BASE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tbl_valid,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_cfg_w_en,
  output logic              o_cfg_sgn,
  output logic [3:0]        o_cfg_idx,
  output logic [15:0]       o_cfg_base,
  output logic [15:0]       o_cfg_offset
);

  localparam logic [1:0]        S_IDLE    = 2'd0;
  localparam logic [1:0]        S_LOAD    = 2'd1;
  localparam logic [1:0]        S_FLUSH   = 2'd2;
  localparam logic [3:0]        IDX_LAST  = 4'(N_SEG - 1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(TABLE_BASE);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sgn;
  logic [3:0]        r_idx;
  logic              r_done;
  logic              r_tbl_valid;
  logic              r_wr_vld_p1;
  logic              r_wr_sgn_p1;
  logic [3:0]        r_wr_idx_p1;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == S_LOAD) && i_mem_gnt;
  assign w_last   = r_sgn && (r_idx == IDX_LAST);

  // Read sequencer: address and sgn/idx advance only on an accepted read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_sgn       <= 1'b0;
      r_idx       <= 4'd0;
      r_done      <= 1'b0;
      r_tbl_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_tbl_valid <= 1'b0;
            r_addr      <= ADDR_BASE;
            r_sgn       <= 1'b0;
            r_idx       <= 4'd0;
          end
        end
        S_LOAD: begin
          if (i_mem_gnt) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_idx == IDX_LAST) begin
              r_idx <= 4'd0;
              r_sgn <= ~r_sgn;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
            if (w_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b1;
          r_tbl_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write stage p1: tag of the read accepted in the previous cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_vld_p1 <= 1'b0;
      r_wr_sgn_p1 <= 1'b0;
      r_wr_idx_p1 <= 4'd0;
    end else begin
      r_wr_vld_p1 <= w_accept;
      if (w_accept) begin
        r_wr_sgn_p1 <= r_sgn;
        r_wr_idx_p1 <= r_idx;
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_tbl_valid  = r_tbl_valid;
  assign o_mem_rd_en  = (r_state == S_LOAD);
  assign o_mem_addr   = r_addr;
  assign o_cfg_w_en   = r_wr_vld_p1;
  assign o_cfg_sgn    = r_wr_sgn_p1;
  assign o_cfg_idx    = r_wr_idx_p1;
  assign o_cfg_base   = i_mem_rdata[31:16];
  assign o_cfg_offset = i_mem_rdata[15:0];

endmodule

// File: tb/tb_bf16_pwl_cfg_loader.sv
// Bench for bf16_pwl_cfg_loader: directed loads with fixed, toggled and random grants,
// checked against an entry-list model of the expected table replay.
module tb_bf16_pwl_cfg_loader;

  localparam int N_SEG = 13;
  localparam int N_ENT = 2 * N_SEG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        gnt = 1'b0;

  logic        busy_a, done_a, tv_a, rd_en_a, wen_a, sgn_a;
  logic [9:0]  addr_a;
  logic [31:0] rdata_a;
  logic [3:0]  idx_a;
  logic [15:0] base_a, off_a;

  logic        busy_b, done_b, tv_b, rd_en_b, wen_b, sgn_b;
  logic [9:0]  addr_b;
  logic [31:0] rdata_b;
  logic [3:0]  idx_b;
  logic [15:0] base_b, off_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic [36:0] wq[$];
  int          wc[$];
  int          acq[$];
  int          dq[$];
  int          aq[$];
  int          bq[$];
  int          busy_n, busy_first, busy_last, hold_err, tv_at1;
  logic        prev_stall;
  logic [9:0]  prev_addr;

  bf16_pwl_cfg_loader #(.N_SEG(N_SEG), .ADDR_W(10), .TABLE_BASE(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy_a), .o_done(done_a), .o_tbl_valid(tv_a),
    .o_mem_rd_en(rd_en_a), .o_mem_addr(addr_a), .i_mem_gnt(gnt), .i_mem_rdata(rdata_a),
    .o_cfg_w_en(wen_a), .o_cfg_sgn(sgn_a), .o_cfg_idx(idx_a),
    .o_cfg_base(base_a), .o_cfg_offset(off_a)
  );

  bf16_pwl_cfg_loader #(.N_SEG(N_SEG), .ADDR_W(10), .TABLE_BASE(1020)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy_b), .o_done(done_b), .o_tbl_valid(tv_b),
    .o_mem_rd_en(rd_en_b), .o_mem_addr(addr_b), .i_mem_gnt(gnt), .i_mem_rdata(rdata_b),
    .o_cfg_w_en(wen_b), .o_cfg_sgn(sgn_b), .o_cfg_idx(idx_b),
    .o_cfg_base(base_b), .o_cfg_offset(off_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Table word for entry n = (addr - base) mod 1024
  function automatic logic [31:0] tbl_word(input logic [9:0] addr, input int base);
    int n;
    n = (int'(addr) - base + 1024) % 1024;
    return {16'(16'h3F00 + n), 16'(16'h0100 + n)};
  endfunction

  function automatic logic [36:0] exp_entry(input int n);
    return {(n >= N_SEG) ? 1'b1 : 1'b0, 4'(n % N_SEG), 16'(16'h3F00 + n), 16'(16'h0100 + n)};
  endfunction

  // Table memory: one-cycle read latency, garbage when no read was accepted
  always @(posedge clk) begin
    rdata_a <= (rd_en_a && gnt) ? tbl_word(addr_a, 0)    : $urandom;
    rdata_b <= (rd_en_b && gnt) ? tbl_word(addr_b, 1020) : $urandom;
  end

  always @(negedge clk) begin
    if (wen_a) begin
      wq.push_back({sgn_a, idx_a, base_a, off_a});
      wc.push_back(cyc - t0);
    end
    if (done_a) dq.push_back(cyc - t0);
    if (busy_a) begin
      busy_n++;
      if (busy_first < 0) busy_first = cyc - t0;
      busy_last = cyc - t0;
    end
    if (rd_en_a && gnt) begin
      aq.push_back(int'(addr_a));
      acq.push_back(cyc - t0);
    end
    if (rd_en_b && gnt) bq.push_back(int'(addr_b));
    if (prev_stall && rd_en_a && (addr_a !== prev_addr)) hold_err++;
    if (cyc - t0 == 1) tv_at1 = int'(tv_a);
    prev_stall = rd_en_a && !gnt;
    prev_addr  = addr_a;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: gnt=1; 1: gnt 1,0,0 repeating; 2: gnt=1 with start re-pulsed; 3: random gnt
  task automatic do_load(input int mode);
    wq.delete(); wc.delete(); acq.delete(); dq.delete(); aq.delete(); bq.delete();
    busy_n = 0; busy_first = -1; busy_last = -1; hold_err = 0; tv_at1 = -1;
    prev_stall = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 400; k++) begin
      case (mode)
        1:       gnt = (k % 3 == 0);
        3:       gnt = 1'($urandom_range(0, 1));
        default: gnt = 1'b1;
      endcase
      start = (k == 0) || (mode == 2 && (k == 5 || k == 20));
      tick();
      if (dq.size() > 0) break;
    end
    start = 1'b0;
    gnt   = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_load(input string nm, input int mode);
    int bad_seq, bad_lat, bad_a, bad_b;
    chk({nm, "_n_writes"}, wq.size(), N_ENT);
    chk({nm, "_n_done"}, dq.size(), 1);
    bad_seq = 0; bad_lat = 0; bad_a = 0; bad_b = 0;
    for (int i = 0; i < N_ENT; i++) begin
      if (i >= wq.size() || wq[i] !== exp_entry(i)) bad_seq++;
      if (i >= wc.size() || i >= acq.size() || wc[i] != acq[i] + 1) bad_lat++;
      if (i >= aq.size() || aq[i] != i) bad_a++;
      if (i >= bq.size() || bq[i] != (1020 + i) % 1024) bad_b++;
    end
    chk({nm, "_wr_seq_bad"}, bad_seq, 0);
    chk({nm, "_wr_latency_bad"}, bad_lat, 0);
    chk({nm, "_addr_a_bad"}, bad_a, 0);
    chk({nm, "_addr_wrap_b_bad"}, bad_b, 0);
    chk({nm, "_addr_hold_bad"}, hold_err, 0);
    chk({nm, "_tv_cleared"}, tv_at1, 0);
    chk({nm, "_tv_end"}, int'(tv_a), 1);
    if (dq.size() > 0 && wc.size() > 0)
      chk({nm, "_done_after_last_wr"}, dq[0], wc[wc.size()-1] + 1);
    if (mode != 1 && mode != 3) begin
      chk({nm, "_first_read_cyc"}, (acq.size() > 0) ? acq[0] : -1, 1);
      chk({nm, "_done_cyc"}, (dq.size() > 0) ? dq[0] : -1, 28);
      chk({nm, "_busy_first"}, busy_first, 1);
      chk({nm, "_busy_last"}, busy_last, 27);
      chk({nm, "_busy_cycles"}, busy_n, 27);
    end
  endtask

  initial begin
    logic [15:0] rf_base [2][N_SEG];
    logic [15:0] rf_off  [2][N_SEG];
    logic [15:0] y;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_tv", int'(tv_a), 0);
    chk("rst_rd_en", int'(rd_en_a), 0);
    chk("rst_wen", int'(wen_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_cfg_tag", int'({sgn_a, idx_a}), 0);
    rst = 1'b0;
    tick();

    do_load(0);
    check_load("t1", 0);

    do_load(1);
    check_load("t2", 1);

    do_load(2);
    check_load("t3", 2);

    do_load(3);
    check_load("t_rand", 3);

    // Reset in cycle 10 of a load, then a clean reload
    t0 = cyc;
    start = 1'b1;
    gnt = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", int'(busy_a), 0);
    chk("t4_tv", int'(tv_a), 0);
    chk("t4_wen", int'(wen_a), 0);
    tick();
    do_load(0);
    check_load("t4_reload", 0);

    // Downstream evaluation of x=1.0 (sgn 0, idx 7): y = base + (0*offset)>>7
    for (int i = 0; i < wq.size(); i++) begin
      rf_base[wq[i][36]][wq[i][35:32]] = wq[i][31:16];
      rf_off [wq[i][36]][wq[i][35:32]] = wq[i][15:0];
    end
    y = rf_base[0][7] + 16'((32'(0) * 32'(rf_off[0][7])) >> 7);
    chk("t6_mac_y", int'(y), 16'h3F07);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
